stbus_rx_deframer: RTL and testbench

Receive-side ST-BUS deframer feeding the STM32 path of the TDM converter. Oversamples the 4.096 MHz `c4` clock, `f0` frame pulse and `data_from_dt` serial line in the `clk50` domain, aligns to the 125 us frame, and assembles 32 eight-bit time slots. Each frame is written into one bank of a double-buffered channel store. On frame completion the banks swap and `cpu_int` is raised so the STM32 can read the completed frame at its own pace.

---
 rtl/stbus_pkg.sv | 17 +
 rtl/stbus_in_sync.sv | 39 +++
 rtl/stbus_rx_deframer.sv | 179 +++++++++++++++++
 tb/tb_stbus_rx_deframer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stbus_pkg.sv
// rtl/stbus_pkg.sv - ST-BUS frame constants and types shared by the receive and transmit paths
`timescale 1ns/1ps
package stbus_pkg;

    localparam int C4_PER_FRAME = 512;
    localparam int BITS_PER_CH  = 8;
    localparam int C4_CNT_W     = $clog2(C4_PER_FRAME);
    localparam int CH_PER_FRAME = 32;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } stbus_state_t;

    typedef logic [$clog2(CH_PER_FRAME)-1:0] ch_idx_t;

endpackage

// File: rtl/stbus_in_sync.sv
// rtl/stbus_in_sync.sv - N-stage input synchronizer with registered level and edge pulses
`timescale 1ns/1ps
module stbus_in_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last;

    // level is taken from the same register the edge detector compares against,
    // so a rise pulse and the levels of sibling synchronizers line up in time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{INIT}};
            last  <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= raw;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            last <= chain[STAGES-1];
            rise <= chain[STAGES-1] & ~last;
            fall <= ~chain[STAGES-1] & last;
        end
    end

    assign level = last;

endmodule

// File: rtl/stbus_rx_deframer.sv
// rtl/stbus_rx_deframer.sv - ST-BUS receive deframer into a double-buffered channel store
// Optional frame counter: define STBUS_RX_FRAME_CNT_EN.
`timescale 1ns/1ps
module stbus_rx_deframer
    import stbus_pkg::*;
#(
    parameter int CHANNELS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk50,
    input  logic                        reset_n,
    input  logic                        c4,
    input  logic                        f0,
    input  logic                        data_from_dt,
    input  logic [$clog2(CHANNELS)-1:0] rd_addr,
    output logic [7:0]                  rd_data,
    input  logic                        int_ack,
    output logic                        cpu_int,
    output logic                        overrun,
    output logic                        sync_err,
    output logic                        locked,
    output logic [15:0]                 frame_cnt
);

    localparam int CW = $clog2(CHANNELS);

    logic       c4r;
    logic       f0_level;
    logic       data_level;
    logic [5:0] unused_sync;

    stbus_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_c4 (
        .clk   (clk50),
        .rst_n (reset_n),
        .raw   (c4),
        .level (unused_sync[0]),
        .rise  (c4r),
        .fall  (unused_sync[1])
    );

    stbus_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_f0 (
        .clk   (clk50),
        .rst_n (reset_n),
        .raw   (f0),
        .level (f0_level),
        .rise  (unused_sync[2]),
        .fall  (unused_sync[3])
    );

    stbus_in_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_data (
        .clk   (clk50),
        .rst_n (reset_n),
        .raw   (data_from_dt),
        .level (data_level),
        .rise  (unused_sync[4]),
        .fall  (unused_sync[5])
    );

    stbus_state_t             state_q, state_d;
    logic [C4_CNT_W-1:0]      c4_cnt, cnt_cur;
    logic                     fs, frame_end;
    logic                     sample, wr_en, swap, err;
    logic                     wr_bank;
    logic [BITS_PER_CH-2:0]   shreg;
    logic [BITS_PER_CH-1:0]   byte_next;
    logic [CW-1:0]            wr_ch;
    logic [BITS_PER_CH-1:0]   mem [2][CHANNELS];

    // cnt_cur is the position of the edge being processed; c4_cnt holds the previous one
    assign fs        = c4r & ~f0_level;
    assign cnt_cur   = fs ? '0 : c4_cnt + 1'b1;
    assign frame_end = (c4_cnt == C4_CNT_W'(C4_PER_FRAME - 1));
    assign byte_next = {shreg, data_level};
    assign wr_ch     = cnt_cur[4 +: CW];
    assign wr_en     = sample & (cnt_cur[3:1] == 3'b111);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sample  = 1'b0;
        swap    = 1'b0;
        err     = 1'b0;
        if (c4r) begin
            case (state_q)
                HUNT: begin
                    if (fs) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fs) begin
                        swap = frame_end;
                        err  = ~frame_end;
                    end else if (frame_end) begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end else begin
                        sample = cnt_cur[0];
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            c4_cnt   <= '0;
            shreg    <= '0;
            wr_bank  <= 1'b0;
            cpu_int  <= 1'b0;
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (c4r) begin
                c4_cnt <= cnt_cur;
            end
            if (sample) begin
                shreg <= byte_next[BITS_PER_CH-2:0];
            end
            if (swap) begin
                wr_bank <= ~wr_bank;
            end
            // a completing frame beats a simultaneous ack
            if (swap) begin
                cpu_int <= 1'b1;
                overrun <= overrun | cpu_int;
            end else if (int_ack && cpu_int) begin
                cpu_int <= 1'b0;
                overrun <= 1'b0;
            end
            if (err) begin
                sync_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    mem[b][c] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_bank][wr_ch] <= byte_next;
            end
            rd_data <= mem[~wr_bank][rd_addr];
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef STBUS_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (swap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_stbus_rx_deframer.sv
// tb/tb_stbus_rx_deframer.sv - scoreboard bench for stbus_rx_deframer
`timescale 1ns/1ps
module tb_stbus_rx_deframer;

    logic        clk50        = 1'b0;
    logic        reset_n      = 1'b0;
    logic        c4           = 1'b0;
    logic        f0           = 1'b1;
    logic        data_from_dt = 1'b0;
    logic [4:0]  rd_addr      = '0;
    logic        int_ack      = 1'b0;
    logic [7:0]  rd_data;
    logic        cpu_int;
    logic        overrun;
    logic        sync_err;
    logic        locked;
    logic [15:0] frame_cnt;

    always #10 clk50 = ~clk50;

    stbus_rx_deframer #(.CHANNELS(32), .SYNC_STAGES(2)) dut (
        .clk50        (clk50),
        .reset_n      (reset_n),
        .c4           (c4),
        .f0           (f0),
        .data_from_dt (data_from_dt),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .int_ack      (int_ack),
        .cpu_int      (cpu_int),
        .overrun      (overrun),
        .sync_err     (sync_err),
        .locked       (locked),
        .frame_cnt    (frame_cnt)
    );

    typedef struct {
        int          kind;
        logic [15:0] want;
        int          addr;
    } chk_t;

    chk_t        q[$];
    chk_t        mon_it;
    logic [15:0] mon_act;
    logic        req   = 1'b0;
    logic        req_d = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  tx [32];
    logic [7:0]  rb [32];
    int          exp_frames = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "rd_data";
            1:       return "cpu_int";
            2:       return "overrun";
            3:       return "sync_err";
            4:       return "locked";
            default: return "frame_cnt";
        endcase
    endfunction

    always @(posedge clk50) req_d <= req;

    always @(negedge clk50) begin
        if (req_d) begin
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL scoreboard: output presented with empty expect queue");
            end else begin
                mon_it = q.pop_front();
                case (mon_it.kind)
                    0:       mon_act = {8'h00, rd_data};
                    1:       mon_act = {15'h0, cpu_int};
                    2:       mon_act = {15'h0, overrun};
                    3:       mon_act = {15'h0, sync_err};
                    4:       mon_act = {15'h0, locked};
                    default: mon_act = frame_cnt;
                endcase
                if (mon_act !== mon_it.want) begin
                    bad = bad + 1;
                    $display("FAIL %s (addr %0d): got %h want %h at %0t",
                             kname(mon_it.kind), mon_it.addr, mon_act, mon_it.want, $time);
                end
            end
        end
    end

    task automatic expect_val(input int kind, input logic [15:0] want, input int addr);
        @(negedge clk50);
        if (kind == 0) rd_addr = addr[4:0];
        q.push_back('{kind: kind, want: want, addr: addr});
        req = 1'b1;
        @(negedge clk50);
        req = 1'b0;
    endtask

    function automatic logic [15:0] fc_exp();
`ifdef STBUS_RX_FRAME_CNT_EN
        return exp_frames[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_status(input logic ci, input logic ov, input logic se, input logic lk);
        expect_val(1, {15'h0, ci}, 0);
        expect_val(2, {15'h0, ov}, 0);
        expect_val(3, {15'h0, se}, 0);
        expect_val(4, {15'h0, lk}, 0);
        expect_val(5, fc_exp(), 0);
    endtask

    task automatic check_bank();
        for (int i = 0; i < 32; i++) expect_val(0, {8'h00, rb[i]}, i);
    endtask

    task automatic check_some();
        expect_val(0, {8'h00, rb[0]}, 0);
        expect_val(0, {8'h00, rb[15]}, 15);
        expect_val(0, {8'h00, rb[31]}, 31);
    endtask

    // one c4 period of 10 clk50 cycles; inputs change while c4 is low
    task automatic c4_edge(input logic fs, input logic b);
        c4           = 1'b0;
        f0           = ~fs;
        data_from_dt = b;
        repeat (5) @(negedge clk50);
        c4 = 1'b1;
        repeat (5) @(negedge clk50);
    endtask

    task automatic body_edges(input int from, input int to);
        logic [7:0] byt;
        for (int k = from; k <= to; k++) begin
            byt = tx[k >> 4];
            c4_edge(1'b0, (k % 2 == 1) ? byt[7 - ((k >> 1) % 8)] : 1'b0);
        end
    endtask

    task automatic body();
        body_edges(1, 511);
    endtask

    task automatic fs_edge();
        c4_edge(1'b1, 1'b0);
    endtask

    task automatic do_ack();
        @(negedge clk50);
        int_ack = 1'b1;
        @(negedge clk50);
        int_ack = 1'b0;
    endtask

    task automatic model_swap();
        for (int i = 0; i < 32; i++) rb[i] = tx[i];
        exp_frames = exp_frames + 1;
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset_n      = 1'b0;
        c4           = 1'b0;
        f0           = 1'b1;
        data_from_dt = 1'b0;
        exp_frames   = 0;
        for (int i = 0; i < 32; i++) rb[i] = 8'h00;
        check_status(1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(0, 16'h0000, 9);
        @(negedge clk50);
        reset_n = 1'b1;
        check_some();
    endtask

    initial begin
        #2_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rb[i] = 8'h00;
        repeat (3) @(negedge clk50);
        check_status(1'b0, 1'b0, 1'b0, 1'b0);
        expect_val(0, 16'h0000, 3);
        @(negedge clk50);
        reset_n = 1'b1;
        expect_val(0, 16'h0000, 7);
        for (int i = 0; i < 8; i++) c4_edge(1'b0, 1'b0);
        expect_val(4, 16'h0000, 0);

        // lock frame with A0+n, completes on the next pulse
        for (int i = 0; i < 32; i++) tx[i] = 8'hA0 + 8'(i);
        fs_edge();
        check_status(1'b0, 1'b0, 1'b0, 1'b1);
        body();
        expect_val(1, 16'h0000, 0);
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b0, 1'b1);
        check_bank();
        do_ack();
        expect_val(1, 16'h0000, 0);

        for (int i = 0; i < 32; i++) tx[i] = (i % 2 == 0) ? 8'h55 : 8'hAA;
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b0, 1'b1);
        check_bank();
        do_ack();
        check_status(1'b0, 1'b0, 1'b0, 1'b1);

        // two completions without ack
        for (int i = 0; i < 32; i++) tx[i] = 8'h10 + 8'(i);
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) tx[i] = 8'hC0 ^ 8'(i);
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b1, 1'b0, 1'b1);
        check_bank();
        do_ack();
        check_status(1'b0, 1'b0, 1'b0, 1'b1);
        do_ack();
        check_status(1'b0, 1'b0, 1'b0, 1'b1);

        body_edges(1, 100);
        do_reset();

        // early frame pulse
        for (int i = 0; i < 32; i++) tx[i] = 8'h20 + 8'(i);
        fs_edge();
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b0, 1'b1);
        do_ack();
        for (int i = 0; i < 32; i++) tx[i] = 8'h33;
        body_edges(1, 200);
        fs_edge();
        check_status(1'b0, 1'b0, 1'b1, 1'b1);
        check_some();
        for (int i = 0; i < 32; i++) tx[i] = 8'h60 + 8'(i);
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b1, 1'b1);
        check_bank();
        do_ack();

        body_edges(1, 50);
        do_reset();

        // missing frame pulse
        for (int i = 0; i < 32; i++) tx[i] = 8'h70 + 8'(i);
        fs_edge();
        body();
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b0, 1'b1);
        do_ack();
        for (int i = 0; i < 32; i++) tx[i] = 8'hE0 + 8'(i);
        body();
        c4_edge(1'b0, 1'b0);
        check_status(1'b0, 1'b0, 1'b1, 1'b0);
        check_some();
        for (int i = 0; i < 50; i++) c4_edge(1'b0, 1'b0);
        expect_val(4, 16'h0000, 0);
        fs_edge();
        check_status(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) tx[i] = 8'h80 + 8'(i);
        body();
        expect_val(1, 16'h0000, 0);
        fs_edge();
        model_swap();
        check_status(1'b1, 1'b0, 1'b1, 1'b1);
        check_bank();
        do_ack();
        check_status(1'b0, 1'b0, 1'b1, 1'b1);

        repeat (5) @(negedge clk50);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
